// File: rtl/uart_seri_verici.sv
// UART serial transmitter: pulls bytes from a FWFT FIFO and shifts them out LSB-first.
// Define UART_PARITE_EN to insert an even-parity bit after the MSB.
module uart_seri_verici #(
  parameter int unsigned DATA_BIT = 8,
  parameter int unsigned STOP_BIT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tx_en_i,
  input  logic [15:0]         baud_div_i,
  input  logic                veri_gecerli_i,
  input  logic [DATA_BIT-1:0] veri_i,
  output logic                consume_o,
  output logic                tx_o,
  output logic                hazir_o
);

  localparam int unsigned CntW = $clog2(DATA_BIT + 1);

  typedef enum logic [2:0] {
    StBosta,
    StBasla,
    StVeri,
`ifdef UART_PARITE_EN
    StParite,
`endif
    StDur
  } durum_e;

  durum_e              durum_q, durum_d;
  logic [15:0]         sayac_q, sayac_d;
  logic [15:0]         per_q, per_d;
  logic [CntW-1:0]     bit_q, bit_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                hazir_q;
  logic                baslat;
  logic                yeni_cerceve;
  logic                sayac_bitti;
  logic [15:0]         per_yeni;
`ifdef UART_PARITE_EN
  logic                parite_q, parite_d;
`endif

  // Reset gates the pop so no byte is lost while the FSM is held in BOSTA.
  assign yeni_cerceve = tx_en_i & veri_gecerli_i & ~rst_i;
  // Counters hold period-1 so a divisor of 0 and 1 both give one-cycle bits.
  assign per_yeni     = (baud_div_i == 16'd0) ? 16'd0 : baud_div_i - 16'd1;
  assign sayac_bitti  = (sayac_q == 16'd0);

  always_comb begin
    durum_d   = durum_q;
    sayac_d   = sayac_q;
    per_d     = per_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    consume_o = 1'b0;
    baslat    = 1'b0;
`ifdef UART_PARITE_EN
    parite_d  = parite_q;
`endif

    unique case (durum_q)
      StBosta: begin
        if (yeni_cerceve) baslat = 1'b1;
      end
      StBasla: begin
        if (sayac_bitti) begin
          durum_d = StVeri;
          tx_d    = shift_q[0];
          sayac_d = per_q;
          bit_d   = '0;
        end else begin
          sayac_d = sayac_q - 16'd1;
        end
      end
      StVeri: begin
        if (sayac_bitti) begin
          sayac_d = per_q;
          if (bit_q == CntW'(DATA_BIT - 1)) begin
`ifdef UART_PARITE_EN
            durum_d = StParite;
            tx_d    = parite_q;
`else
            durum_d = StDur;
            tx_d    = 1'b1;
            bit_d   = '0;
`endif
          end else begin
            bit_d   = bit_q + CntW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          sayac_d = sayac_q - 16'd1;
        end
      end
`ifdef UART_PARITE_EN
      StParite: begin
        if (sayac_bitti) begin
          durum_d = StDur;
          tx_d    = 1'b1;
          sayac_d = per_q;
          bit_d   = '0;
        end else begin
          sayac_d = sayac_q - 16'd1;
        end
      end
`endif
      StDur: begin
        if (sayac_bitti) begin
          if (bit_q == CntW'(STOP_BIT - 1)) begin
            if (yeni_cerceve) baslat = 1'b1;
            else              durum_d = StBosta;
          end else begin
            bit_d   = bit_q + CntW'(1);
            sayac_d = per_q;
          end
        end else begin
          sayac_d = sayac_q - 16'd1;
        end
      end
      default: durum_d = StBosta;
    endcase

    // Frame start is shared by BOSTA and the last stop cycle (back-to-back frames).
    if (baslat) begin
      consume_o = 1'b1;
      shift_d   = veri_i;
      per_d     = per_yeni;
      sayac_d   = per_yeni;
      tx_d      = 1'b0;
      durum_d   = StBasla;
`ifdef UART_PARITE_EN
      parite_d  = ^veri_i;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q  <= StBosta;
      sayac_q  <= '0;
      per_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      hazir_q  <= 1'b1;
`ifdef UART_PARITE_EN
      parite_q <= 1'b0;
`endif
    end else begin
      durum_q  <= durum_d;
      sayac_q  <= sayac_d;
      per_q    <= per_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      hazir_q  <= (durum_d == StBosta);
`ifdef UART_PARITE_EN
      parite_q <= parite_d;
`endif
    end
  end

  assign tx_o    = tx_q;
  assign hazir_o = hazir_q;

endmodule

// File: tb/tb_uart_seri_verici.sv
// Self-checking bench for uart_seri_verici: fixed vector table, directed corner cases,
// and randomized frames checked against a bit-list frame model.
module tb_uart_seri_verici;

`ifdef UART_PARITE_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + 8 + P + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        gecerli = 1'b1;
  logic [7:0]  veri = 8'h00;
  logic        consume, tx, hazir;

  int checks = 0;
  int failures = 0;

  uart_seri_verici #(.DATA_BIT(8), .STOP_BIT(1)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tx_en_i       (tx_en),
    .baud_div_i    (baud_div),
    .veri_gecerli_i(gecerli),
    .veri_i        (veri),
    .consume_o     (consume),
    .tx_o          (tx),
    .hazir_o       (hazir)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Frame as the list of line levels in send order: start, data LSB first, [parity], stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = d[i];
    if (P == 1) f[9] = ^d;
    return f;
  endfunction

  task automatic wait_consume(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (consume === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples every cycle of one frame, starting with the cycle after the consume cycle.
  task automatic sample_frame(input string nm, input logic [10:0] eb, input int per,
                              output bit lc);
    int bad, hz, cs, tot;
    bad = 0; hz = 0; cs = 0; lc = 1'b0;
    tot = NBITS * per;
    for (int i = 0; i < tot; i++) begin
      @(negedge clk);
      if (tx !== eb[i / per]) bad++;
      if (hazir !== 1'b0) hz++;
      if (i < tot - 1 && consume !== 1'b0) cs++;
      lc = consume;
    end
    check({nm, " tx_bad_cycles"}, bad, 0);
    check({nm, " hazir_high_cycles"}, hz, 0);
    check({nm, " midframe_consumes"}, cs, 0);
  endtask

  task automatic end_check(input string nm);
    @(negedge clk);
    check({nm, " end_hazir"}, hazir, 1);
    check({nm, " end_tx"}, tx, 1);
  endtask

  task automatic run_frame(input string nm, input logic [15:0] baud, input logic [7:0] d,
                           input logic [10:0] eb, input int per);
    bit ok, lc;
    @(posedge clk); #1;
    baud_div = baud; veri = d; gecerli = 1'b1; tx_en = 1'b1;
    wait_consume(ok);
    check({nm, " consume_seen"}, ok, 1);
    @(posedge clk); #1;
    gecerli  = 1'b0;
    veri     = 8'($urandom);
    baud_div = 16'($urandom_range(1, 9));
    sample_frame(nm, eb, per, lc);
    check({nm, " last_consume"}, lc, 0);
    end_check(nm);
  endtask

  typedef struct {
    logic [15:0] baud;
    logic [7:0]  data;
    int          per;
    logic [10:0] exp_bits;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok, lc;
    int bad, per;
    logic [15:0] b;
    logic [7:0]  d;

`ifdef UART_PARITE_EN
    vecs[0] = '{16'd4, 8'hA5, 4, 11'h54A};
    vecs[1] = '{16'd0, 8'h55, 1, 11'h4AA};
    vecs[2] = '{16'd2, 8'h07, 2, 11'h60E};
    vecs[3] = '{16'd1, 8'hFF, 1, 11'h5FE};
    vecs[4] = '{16'd3, 8'h3C, 3, 11'h478};
`else
    vecs[0] = '{16'd4, 8'hA5, 4, 11'h34A};
    vecs[1] = '{16'd0, 8'h55, 1, 11'h2AA};
    vecs[2] = '{16'd3, 8'h00, 3, 11'h200};
    vecs[3] = '{16'd1, 8'hFF, 1, 11'h3FE};
    vecs[4] = '{16'd2, 8'h3C, 2, 11'h278};
`endif

    // Reset held with a valid, enabled FIFO: nothing may be popped.
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset hazir", hazir, 1);
    check("reset consume", consume, 0);
    @(posedge clk); #1;
    rst = 1'b0; gecerli = 1'b0;

    foreach (vecs[k]) run_frame($sformatf("vec%0d", k), vecs[k].baud, vecs[k].data,
                                vecs[k].exp_bits, vecs[k].per);

    // Back-to-back: second pop lands on the last stop cycle, no idle gap.
    @(posedge clk); #1;
    baud_div = 16'd4; veri = 8'h00; gecerli = 1'b1; tx_en = 1'b1;
    wait_consume(ok);
    check("b2b first_consume", ok, 1);
    @(posedge clk); #1;
    veri = 8'hFF;
    sample_frame("b2b f0", model_frame(8'h00), 4, lc);
    check("b2b second_consume_at_stop_end", lc, 1);
    @(posedge clk); #1;
    gecerli = 1'b0;
    sample_frame("b2b f1", model_frame(8'hFF), 4, lc);
    check("b2b f1 last_consume", lc, 0);
    end_check("b2b");

    // Enable gating.
    @(posedge clk); #1;
    tx_en = 1'b0; gecerli = 1'b1; veri = 8'h81; baud_div = 16'd2;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (consume !== 1'b0 || tx !== 1'b1 || hazir !== 1'b1) bad++;
    end
    check("gate idle_bad_cycles", bad, 0);
    @(posedge clk); #1;
    tx_en = 1'b1;
    @(negedge clk);
    check("gate consume_same_cycle", consume, 1);
    @(posedge clk); #1;
    gecerli = 1'b0;
    sample_frame("gate", model_frame(8'h81), 2, lc);
    end_check("gate");

    // Reset during data bit 3, FIFO still valid.
    @(posedge clk); #1;
    baud_div = 16'd8; veri = 8'hC3; gecerli = 1'b1; tx_en = 1'b1;
    wait_consume(ok);
    check("rst first_consume", ok, 1);
    @(posedge clk); #1;
    veri = 8'h5A;
    repeat (34) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst tx", tx, 1);
    check("rst hazir", hazir, 1);
    check("rst consume_held", consume, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst consume_after_release", consume, 1);
    @(posedge clk); #1;
    gecerli = 1'b0;
    sample_frame("rst", model_frame(8'h5A), 8, lc);
    end_check("rst");

    // Randomized frames against the model.
    for (int i = 0; i < 16; i++) begin
      b   = 16'($urandom_range(0, 6));
      d   = 8'($urandom);
      per = (b == 16'd0) ? 1 : int'(b);
      run_frame($sformatf("rnd%0d", i), b, d, model_frame(d), per);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
